jstk_poll_scheduler: RTL and testbench

- Shares one PmodJSTK SPI master between two joysticks (player 0, player 1) on a common MISO/MOSI/SCLK bus with muxed SS.
- On each poll tick, sequences a transaction per player: selects the player, pulses the master's send request, waits for its busy window, latches the 40-bit frame, and decodes it into directional controls with hysteresis.
- Sits between the SPI master and game_logic. Replaces the free-running sndRec hookup and the raw threshold compares in the top level.

---
 rtl/jstk_poll_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_jstk_poll_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_scheduler.sv
// Time-shares one PmodJSTK SPI master between two joysticks: one transaction per
// player per poll tick, frame decode with hysteresis, and per-player timeout faults.

module jstk_dir_decode #(
  parameter int UP_TH    = 630,
  parameter int LEFT_TH  = 300,
  parameter int RIGHT_TH = 630,
  parameter int HYST     = 16
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       up,
  input  logic       left,
  input  logic       right,
  output logic       up_nxt,
  output logic       left_nxt,
  output logic       right_nxt
);
  localparam logic [9:0] UP_SET = 10'(UP_TH);
  localparam logic [9:0] UP_CLR = 10'(UP_TH - HYST);
  localparam logic [9:0] RT_SET = 10'(RIGHT_TH);
  localparam logic [9:0] RT_CLR = 10'(RIGHT_TH - HYST);
  localparam logic [9:0] LF_SET = 10'(LEFT_TH);
  localparam logic [9:0] LF_CLR = 10'(LEFT_TH + HYST);

  // Inside the band each direction keeps its previous value.
  always_comb begin
    up_nxt    = up;
    left_nxt  = left;
    right_nxt = right;
    if (y >= UP_SET)      up_nxt = 1'b1;
    else if (y < UP_CLR)  up_nxt = 1'b0;
    if (x >= RT_SET)      right_nxt = 1'b1;
    else if (x < RT_CLR)  right_nxt = 1'b0;
    if (x <= LF_SET)      left_nxt = 1'b1;
    else if (x > LF_CLR)  left_nxt = 1'b0;
  end
endmodule

module jstk_poll_scheduler #(
  parameter int          UP_TH    = 630,
  parameter int          LEFT_TH  = 300,
  parameter int          RIGHT_TH = 630,
  parameter int          HYST     = 16,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        spi_busy,
  input  logic [39:0] spi_dout,
  output logic        spi_snd,
  output logic        spi_sel,
  output logic [7:0]  spi_din,
  input  logic [1:0]  led0,
  input  logic [1:0]  led1,
  output logic [9:0]  p0_x,
  output logic [9:0]  p0_y,
  output logic [9:0]  p1_x,
  output logic [9:0]  p1_y,
  output logic        p0_up,
  output logic        p0_left,
  output logic        p0_right,
  output logic        p1_up,
  output logic        p1_left,
  output logic        p1_right,
  output logic        p0_fault,
  output logic        p1_fault,
  output logic [7:0]  frame_cnt
);
  localparam int         NUM_PLAYERS = 2;
  localparam logic [5:0] CMD_HI      = 6'b100000;

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, LATCH, ABORT, NEXT} state_t;

  state_t                          state;
  logic                            pending;
  logic [15:0]                     timer;
  logic [39:0]                     frame_q;
  logic [NUM_PLAYERS-1:0][9:0]     pos_x, pos_y;
  logic [NUM_PLAYERS-1:0]          up, left, right, fault;
  logic [NUM_PLAYERS-1:0]          up_nxt, left_nxt, right_nxt;
  logic [9:0]                      frm_x, frm_y;

  // Frame is captured on the busy falling edge so LATCH never depends on the
  // master holding spi_dout afterwards.
  assign frm_x = {frame_q[25:24], frame_q[39:32]};
  assign frm_y = {frame_q[9:8],   frame_q[23:16]};

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_dec
    jstk_dir_decode #(
      .UP_TH(UP_TH), .LEFT_TH(LEFT_TH), .RIGHT_TH(RIGHT_TH), .HYST(HYST)
    ) u_dec (
      .x(frm_x), .y(frm_y),
      .up(up[p]), .left(left[p]), .right(right[p]),
      .up_nxt(up_nxt[p]), .left_nxt(left_nxt[p]), .right_nxt(right_nxt[p])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      timer     <= '0;
      frame_q   <= '0;
      spi_snd   <= 1'b0;
      spi_sel   <= 1'b0;
      spi_din   <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      up        <= '0;
      left      <= '0;
      right     <= '0;
      fault     <= '0;
      frame_cnt <= '0;
    end else begin
      spi_snd <= 1'b0;
      // Ticks arriving mid-round collapse into a single follow-up round.
      if (tick && state != IDLE) pending <= 1'b1;
      unique case (state)
        IDLE: if (tick || pending) begin
          pending <= 1'b0;
          spi_sel <= 1'b0;
          spi_din <= {CMD_HI, led0};
          spi_snd <= 1'b1;
          state   <= START;
        end
        START: begin
          timer <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (spi_busy) begin
            timer <= '0;
            state <= WAIT_LO;
          end else if (timer == TIMEOUT) state <= ABORT;
          else timer <= timer + 16'd1;
        end
        WAIT_LO: begin
          if (!spi_busy) begin
            frame_q <= spi_dout;
            state   <= LATCH;
          end else if (timer == TIMEOUT) state <= ABORT;
          else timer <= timer + 16'd1;
        end
        LATCH: begin
          pos_x[spi_sel] <= frm_x;
          pos_y[spi_sel] <= frm_y;
          up[spi_sel]    <= up_nxt[spi_sel];
          left[spi_sel]  <= left_nxt[spi_sel];
          right[spi_sel] <= right_nxt[spi_sel];
          fault[spi_sel] <= 1'b0;
          frame_cnt      <= frame_cnt + 8'd1;
          state          <= NEXT;
        end
        ABORT: begin
          fault[spi_sel] <= 1'b1;
          up[spi_sel]    <= 1'b0;
          left[spi_sel]  <= 1'b0;
          right[spi_sel] <= 1'b0;
          state          <= NEXT;
        end
        NEXT: begin
          if (!spi_sel) begin
            spi_sel <= 1'b1;
            spi_din <= {CMD_HI, led1};
            spi_snd <= 1'b1;
            state   <= START;
          end else begin
            spi_sel <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_x     = pos_x[0];
  assign p0_y     = pos_y[0];
  assign p1_x     = pos_x[1];
  assign p1_y     = pos_y[1];
  assign p0_up    = up[0];
  assign p0_left  = left[0];
  assign p0_right = right[0];
  assign p1_up    = up[1];
  assign p1_left  = left[1];
  assign p1_right = right[1];
  assign p0_fault = fault[0];
  assign p1_fault = fault[1];
endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Scoreboard bench: a PmodJSTK master model feeds frames (or withholds busy) and
// queues the expected player state; a monitor checks it at each send request.
`timescale 1ns/1ps
module tb_jstk_poll_scheduler;
  localparam int          UP_TH = 630, LEFT_TH = 300, RIGHT_TH = 630, HYST = 16;
  localparam logic [15:0] TO    = 16'd200;

  logic        clk = 1'b0, rst = 1'b0, tick = 1'b0, spi_busy = 1'b0;
  logic [39:0] spi_dout = '0;
  logic [1:0]  led0 = '0, led1 = '0;
  logic        spi_snd, spi_sel;
  logic [7:0]  spi_din, frame_cnt;
  logic [9:0]  p0_x, p0_y, p1_x, p1_y;
  logic        p0_up, p0_left, p0_right, p1_up, p1_left, p1_right, p0_fault, p1_fault;

  always #5 clk = ~clk;

  jstk_poll_scheduler #(
    .UP_TH(UP_TH), .LEFT_TH(LEFT_TH), .RIGHT_TH(RIGHT_TH), .HYST(HYST), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .spi_busy(spi_busy), .spi_dout(spi_dout),
    .spi_snd(spi_snd), .spi_sel(spi_sel), .spi_din(spi_din), .led0(led0), .led1(led1),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
    .p0_up(p0_up), .p0_left(p0_left), .p0_right(p0_right),
    .p1_up(p1_up), .p1_left(p1_left), .p1_right(p1_right),
    .p0_fault(p0_fault), .p1_fault(p1_fault), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [9:0] x0, y0, x1, y1;
    logic [5:0] dirs;
    logic [1:0] flt;
    logic [7:0] fcnt;
  } snap_t;

  snap_t       expq[$];
  logic [19:0] fq0[$], fq1[$];
  int          vectors = 0, errors = 0, snd_cnt = 0;
  int          busy_len = 0;
  bit          rand_to = 1'b0;
  logic [1:0]  force_to = '0;
  logic [3:0]  led_at_edge = '0;
  bit          exp_sel = 1'b0;

  // Reference model: player state as plain integers and flags.
  int mx[2], my[2], mfcnt;
  bit mup[2], mleft[2], mright[2], mflt[2];

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mx[p] = 0; my[p] = 0; mup[p] = 0; mleft[p] = 0; mright[p] = 0; mflt[p] = 0;
    end
    mfcnt = 0;
  endtask

  task automatic model_latch(input int p, input int x, input int y);
    if (y >= UP_TH) mup[p] = 1; else if (y < UP_TH - HYST) mup[p] = 0;
    if (x >= RIGHT_TH) mright[p] = 1; else if (x < RIGHT_TH - HYST) mright[p] = 0;
    if (x <= LEFT_TH) mleft[p] = 1; else if (x > LEFT_TH + HYST) mleft[p] = 0;
    mx[p] = x; my[p] = y; mflt[p] = 0;
    mfcnt = (mfcnt + 1) % 256;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.x0 = 10'(mx[0]); s.y0 = 10'(my[0]); s.x1 = 10'(mx[1]); s.y1 = 10'(my[1]);
    s.dirs = {mup[0], mleft[0], mright[0], mup[1], mleft[1], mright[1]};
    s.flt  = {mflt[0], mflt[1]};
    s.fcnt = 8'(mfcnt);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    return {p0_x, p0_y, p1_x, p1_y, p0_up, p0_left, p0_right, p1_up, p1_left, p1_right,
            p0_fault, p1_fault, frame_cnt};
  endfunction

  function automatic logic [65:0] all_out();
    return {spi_snd, spi_sel, spi_din, dut_snap()};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pending(input string name);
    snap_t e;
    if (expq.size() > 0) begin
      while (expq.size() > 0) e = expq.pop_front();
      chk(name, 66'(dut_snap()), 66'(e));
    end
  endtask

  // Master model: answers each send request with a frame, or stays silent.
  task automatic serve(input logic sel);
    int x, y, blen;
    logic [63:0] r;
    logic [39:0] d;
    logic [19:0] v;
    if (force_to[sel] || (rand_to && $urandom_range(0, 15) == 0)) begin
      mflt[sel] = 1; mup[sel] = 0; mleft[sel] = 0; mright[sel] = 0;
      expq.push_back(model_snap());
      return;
    end
    if (sel == 1'b0 && fq0.size() > 0) begin v = fq0.pop_front(); x = int'(v[19:10]); y = int'(v[9:0]); end
    else if (sel == 1'b1 && fq1.size() > 0) begin v = fq1.pop_front(); x = int'(v[19:10]); y = int'(v[9:0]); end
    else begin
      x = ($urandom_range(0, 2) == 0) ? $urandom_range(280, 650) : $urandom_range(0, 1023);
      y = ($urandom_range(0, 2) == 0) ? $urandom_range(600, 650) : $urandom_range(0, 1023);
    end
    r = {$urandom(), $urandom()};
    d = r[39:0];
    d[39:32] = 8'(x); d[25:24] = 2'(x >> 8);
    d[23:16] = 8'(y); d[9:8]   = 2'(y >> 8);
    blen = (busy_len > 0) ? busy_len : $urandom_range(2, 12);
    repeat (2) begin @(posedge clk); if (!rst) return; end
    #1 spi_busy = 1'b1; spi_dout = d;
    repeat (blen) begin
      @(posedge clk);
      if (!rst) begin #1 spi_busy = 1'b0; return; end
    end
    #1 spi_busy = 1'b0;
    model_latch(int'(sel), x, y);
    expq.push_back(model_snap());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst && spi_snd) serve(spi_sel);
    end
  end

  always @(posedge clk) led_at_edge = {led1, led0};

  // Monitor: at every send request the previous transaction is complete.
  always @(negedge clk) begin
    if (!rst) exp_sel = 1'b0;
    else if (spi_snd) begin
      snd_cnt++;
      chk("sel_din", 66'({spi_sel, spi_din}),
          66'({exp_sel, 6'b100000, exp_sel ? led_at_edge[3:2] : led_at_edge[1:0]}));
      exp_sel = ~exp_sel;
      check_pending("snap_at_snd");
    end
  end

  task automatic do_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0, n = 0;
    while (quiet < int'(TO) + 30 && n < 20000) begin
      @(posedge clk); n++;
      if (spi_snd || spi_busy) quiet = 0; else quiet++;
    end
    if (n >= 20000) begin
      vectors++; errors++;
      $display("FAIL %s: idle wait expired after %0d cycles, want quiet bus", name, n);
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!spi_busy && n < 100) begin @(posedge clk); n++; end
    if (!spi_busy) begin
      vectors++; errors++;
      $display("FAIL %s: busy never seen in %0d cycles, want busy", name, n);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

  int c0;
  logic [9:0] hx[6];
  logic [1:0] hexp[6];

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_out(), 66'd0);
    @(negedge clk) rst = 1'b1;

    // Basic round: both players x=700, y=512, long busy window.
    busy_len = 100; led0 = 2'b01; led1 = 2'b10;
    fq0.push_back({10'd700, 10'd512}); fq1.push_back({10'd700, 10'd512});
    c0 = snd_cnt;
    do_tick(); wait_idle("round1"); check_pending("round1_drain");
    chk("round1_snd_count", 66'(snd_cnt - c0), 66'd2);
    chk("round1_p0_right_up", 66'({p0_right, p0_up}), 66'(2'b10));
    chk("round1_frame_cnt", 66'(frame_cnt), 66'd2);

    // Hysteresis on player 0.
    busy_len = 0;
    hx   = '{10'd640, 10'd620, 10'd610, 10'd300, 10'd315, 10'd317};
    hexp = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      fq0.push_back({hx[i], 10'd512});
      do_tick(); wait_idle("hyst"); check_pending("hyst_drain");
      chk($sformatf("hyst_lr_x%0d", hx[i]), 66'({p0_left, p0_right}), 66'(hexp[i]));
    end

    // Player 1 never answers, then recovers on the next round.
    fq1.push_back({10'd640, 10'd700});
    force_to = 2'b10;
    do_tick(); wait_idle("timeout"); check_pending("timeout_drain");
    chk("timeout_p1", 66'({p1_fault, p1_up, p1_left, p1_right}), 66'(4'b1000));
    force_to = 2'b00;
    c0 = snd_cnt;
    do_tick(); wait_idle("recover"); check_pending("recover_drain");
    chk("recover_snd_count", 66'(snd_cnt - c0), 66'd2);
    chk("recover_p1_fault", 66'(p1_fault), 66'd0);

    // Three ticks during one transaction collapse to one extra round.
    busy_len = 20;
    c0 = snd_cnt;
    do_tick(); wait_busy("pending");
    repeat (3) begin do_tick(); @(posedge clk); end
    wait_idle("pending"); check_pending("pending_drain");
    chk("pending_snd_count", 66'(snd_cnt - c0), 66'd4);

    // Reset while the master is mid-transfer.
    do_tick(); wait_busy("rst_mid");
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_mid_outputs", all_out(), 66'd0);
    expq.delete(); fq0.delete(); fq1.delete(); model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    c0 = snd_cnt;
    repeat (30) @(posedge clk);
    chk("rst_no_snd", 66'(snd_cnt - c0), 66'd0);
    do_tick(); wait_idle("post_rst"); check_pending("post_rst_drain");
    chk("post_rst_snd_count", 66'(snd_cnt - c0), 66'd2);

    // Randomized ticks, LEDs, frames and occasional timeouts; frame_cnt wraps.
    busy_len = 0; rand_to = 1'b1;
    repeat (300) begin
      @(posedge clk); #1 led0 = 2'($urandom()); led1 = 2'($urandom());
      do_tick();
      repeat ($urandom_range(3, 60)) @(posedge clk);
    end
    rand_to = 1'b0;
    wait_idle("random"); check_pending("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
